// File: rtl/mtr_pwm_if.sv
// Signal bundle between the balance controller / test driver and the H-bridge PWM back end.
// The master drives speed, direction and enable; the slave returns the bridge legs and sync.
interface mtr_pwm_if;
    logic        pwr_up;
    logic [10:0] lft_spd;
    logic        lft_rev;
    logic [10:0] rght_spd;
    logic        rght_rev;
    logic        PWM_frwrd_lft;
    logic        PWM_rev_lft;
    logic        PWM_frwrd_rght;
    logic        PWM_rev_rght;
    logic        pwm_synch;

    modport master (
        output pwr_up, lft_spd, lft_rev, rght_spd, rght_rev,
        input  PWM_frwrd_lft, PWM_rev_lft, PWM_frwrd_rght, PWM_rev_rght, pwm_synch
    );

    modport slave (
        input  pwr_up, lft_spd, lft_rev, rght_spd, rght_rev,
        output PWM_frwrd_lft, PWM_rev_lft, PWM_frwrd_rght, PWM_rev_rght, pwm_synch
    );
endinterface

// File: rtl/mtr_pwm_drv.sv
// Dual-channel H-bridge PWM generator: 2048-clk period, duty/direction double-buffered at the
// period boundary, with forced all-off gap periods whenever a channel reverses direction.
module mtr_pwm_drv #(
    parameter int unsigned GAP_PERIODS = 1
) (
    input logic      clk,
    input logic      rst,
    mtr_pwm_if.slave pwm
);
    localparam logic [2:0] GapLoad = 3'(GAP_PERIODS - 1);

    // Index 0 is the left motor, index 1 the right motor.
    logic [10:0]      cnt_q;
    logic [1:0][10:0] duty_q, duty_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0][2:0]  gap_q, gap_d;
    logic [1:0]       fwd_q, fwd_d;
    logic [1:0]       rev_q, rev_d;
    logic             synch_q;

    logic [1:0][10:0] spd_in;
    logic [1:0]       rev_in;
    logic             latch;

    assign spd_in = {pwm.rght_spd, pwm.lft_spd};
    assign rev_in = {pwm.rght_rev, pwm.lft_rev};
    assign latch  = (cnt_q == 11'd2047);

    always_comb begin
        duty_d = duty_q;
        dir_d  = dir_q;
        gap_d  = gap_q;
        if (latch) begin
            for (int m = 0; m < 2; m++) begin
                if (gap_q[m] != 3'd0) begin
                    gap_d[m]  = gap_q[m] - 3'd1;
                    duty_d[m] = '0;
                end else if (!pwm.pwr_up) begin
                    duty_d[m] = '0;
                end else if (rev_in[m] != dir_q[m]) begin
                    // Reversal: adopt the new direction but hold the bridge off first.
                    dir_d[m]  = rev_in[m];
                    duty_d[m] = '0;
                    gap_d[m]  = GapLoad;
                end else begin
                    duty_d[m] = spd_in[m];
                end
            end
        end
    end

    always_comb begin
        fwd_d = '0;
        rev_d = '0;
        for (int m = 0; m < 2; m++) begin
            fwd_d[m] = (cnt_q < duty_q[m]) && pwm.pwr_up && !dir_q[m];
            rev_d[m] = (cnt_q < duty_q[m]) && pwm.pwr_up && dir_q[m];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            duty_q  <= '0;
            dir_q   <= '0;
            gap_q   <= '0;
            fwd_q   <= '0;
            rev_q   <= '0;
            synch_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_q + 11'd1;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            gap_q   <= gap_d;
            fwd_q   <= fwd_d;
            rev_q   <= rev_d;
            synch_q <= (cnt_q == 11'd0);
        end
    end

    assign pwm.PWM_frwrd_lft  = fwd_q[0];
    assign pwm.PWM_rev_lft    = rev_q[0];
    assign pwm.PWM_frwrd_rght = fwd_q[1];
    assign pwm.PWM_rev_rght   = rev_q[1];
    assign pwm.pwm_synch      = synch_q;
endmodule
